key_event_gen: RTL and testbench

- Consumer side of the button debouncers: takes N debounced, active-low key levels and turns them into discrete key events (PRESS, LONG, REPEAT, RELEASE).
- Events are queued in a small FIFO and delivered over a valid/ready interface to the calculator input-entry FSM.
- Replaces ad-hoc edge detection on debounced lines elsewhere in the design.

---
 rtl/matrix_calc_pkg.sv | 26 ++
 rtl/evt_fifo.sv | 86 ++++++++
 rtl/key_event_gen.sv | 208 ++++++++++++++++++++
 tb/tb_key_event_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_calc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : matrix_calc_pkg
// Brief    : Key event codes and key FSM state encoding shared by key_event_gen.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_calc_pkg;

  localparam logic [1:0] EVT_RELEASE = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    KS_IDLE = 2'b00,
    KS_DOWN = 2'b01,
    KS_RPT  = 2'b10
  } key_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int width_of(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : evt_fifo
// Brief    : First-word fall-through FIFO; head output holds its last value when empty.
// Revision : 1.0 - initial release
// ============================================================================
module evt_fifo
  import matrix_calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = width_of(DEPTH);
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);
  localparam logic [AW:0] c_one   = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdata;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_next;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_depth);
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;
  assign rdata     = r_rdata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      // Head register: load on write into an empty queue, advance on pop.
      if (empty) begin
        if (w_push) begin
          r_rdata <= wdata;
        end
      end else if (w_pop) begin
        if (r_count == c_one) begin
          if (w_push) begin
            r_rdata <= wdata;
          end
        end else begin
          r_rdata <= r_mem[w_rd_next];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_event_gen
// Brief    : Turns debounced active-low key levels into queued PRESS/LONG/REPEAT/RELEASE events.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_gen
  import matrix_calc_pkg::*;
#(
  parameter int N_KEYS        = 5,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_KEYS-1:0]           key_n,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [width_of(N_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_type,
  output logic [N_KEYS-1:0]           key_held,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int KW   = width_of(N_KEYS);
  localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW   = width_of(MAXC);
  localparam logic [CW-1:0] c_long_tc = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] c_rpt_tc  = CW'(REPEAT_CYCLES - 1);

  logic [N_KEYS-1:0]      r_key_q;
  logic                   r_overflow;

  logic [N_KEYS-1:0]      w_pend_v;
  logic [N_KEYS-1:0][1:0] w_pend_t;
  logic [N_KEYS-1:0]      w_drain;
  logic [N_KEYS-1:0]      w_drop;

  logic                   w_found;
  logic [KW-1:0]          w_sel_key;
  logic [1:0]             w_sel_type;
  logic                   w_push_ok;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [KW+1:0]          w_fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= '1;
    end else begin
      r_key_q <= key_n;
    end
  end

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pend_v;
    logic [1:0]    r_pend_t;
    logic          w_raise;
    logic [1:0]    w_rtype;

    // Release is tested first so it beats a LONG/REPEAT terminal count.
    always_comb begin
      w_raise = 1'b0;
      w_rtype = EVT_RELEASE;
      case (r_state)
        KS_IDLE: begin
          if (!r_key_q[gi]) begin
            w_raise = 1'b1;
            w_rtype = EVT_PRESS;
          end
        end
        KS_DOWN: begin
          if (r_key_q[gi]) begin
            w_raise = 1'b1;
            w_rtype = EVT_RELEASE;
          end else if (r_cnt == c_long_tc) begin
            w_raise = 1'b1;
            w_rtype = EVT_LONG;
          end
        end
        KS_RPT: begin
          if (r_key_q[gi]) begin
            w_raise = 1'b1;
            w_rtype = EVT_RELEASE;
          end else if (r_cnt == c_rpt_tc) begin
            w_raise = 1'b1;
            w_rtype = EVT_REPEAT;
          end
        end
        default: begin
          w_raise = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= KS_IDLE;
        r_cnt    <= '0;
        r_pend_v <= 1'b0;
        r_pend_t <= EVT_RELEASE;
      end else begin
        case (r_state)
          KS_IDLE: begin
            if (!r_key_q[gi]) begin
              r_state <= KS_DOWN;
              r_cnt   <= '0;
            end
          end
          KS_DOWN: begin
            if (r_key_q[gi]) begin
              r_state <= KS_IDLE;
            end else if (r_cnt == c_long_tc) begin
              r_state <= KS_RPT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          KS_RPT: begin
            if (r_key_q[gi]) begin
              r_state <= KS_IDLE;
            end else if (r_cnt == c_rpt_tc) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= KS_IDLE;
            r_cnt   <= '0;
          end
        endcase

        if (w_raise && (!r_pend_v || w_drain[gi])) begin
          r_pend_v <= 1'b1;
          r_pend_t <= w_rtype;
        end else if (w_drain[gi]) begin
          r_pend_v <= 1'b0;
        end
      end
    end

    assign w_pend_v[gi] = r_pend_v;
    assign w_pend_t[gi] = r_pend_t;
    assign w_drop[gi]   = w_raise && r_pend_v && !w_drain[gi];
    assign key_held[gi] = (r_state != KS_IDLE);
  end

  assign w_pop     = !w_empty && evt_ready;
  assign w_push_ok = !w_full || w_pop;

  // Fixed priority: the lowest-index pending slot wins the single push per cycle.
  always_comb begin
    w_found    = 1'b0;
    w_sel_key  = '0;
    w_sel_type = EVT_RELEASE;
    w_drain    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (w_pend_v[i] && !w_found) begin
        w_found    = 1'b1;
        w_sel_key  = KW'(i);
        w_sel_type = w_pend_t[i];
        w_drain[i] = w_push_ok;
      end
    end
  end

  assign w_push = w_found && w_push_ok;

  evt_fifo #(
    .WIDTH (KW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata ({w_sel_key, w_sel_type}),
    .pop   (w_pop),
    .rdata (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign evt_valid = !w_empty;
  assign evt_key   = w_fifo_dout[KW+1:2];
  assign evt_type  = w_fifo_dout[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_gen
// Brief    : Directed vector table plus multi-cycle sequences for key_event_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_n = 4'b1111;
  logic       evt_ready = 1'b1;
  logic       clr_overflow = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic [3:0] key_held;
  logic       overflow;

  key_event_gen #(
    .N_KEYS        (4),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_type     (evt_type),
    .key_held     (key_held),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] k;
    logic [1:0] t;
    int         c;
  } ev_t;

  typedef struct {
    logic [3:0] key_n;
    logic       valid;
    logic [1:0] k;
    logic [1:0] t;
    logic [3:0] held;
  } vec_t;

  ev_t  log_q[$];
  vec_t vt[11];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted event (valid && ready) is logged with the cycle it was visible in.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1)
      log_q.push_back('{evt_key, evt_type, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [1:0] k, input logic [1:0] t);
    if (idx >= log_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s: got no event %0d expected key %0d type %0d", name, idx, k, t);
    end else begin
      chk({name, "_key"}, 32'(log_q[idx].k), 32'(k));
      chk({name, "_type"}, 32'(log_q[idx].t), 32'(t));
    end
  endtask

  function automatic int dcyc(input int a, input int b);
    if (a >= log_q.size() || b >= log_q.size()) return -1;
    return log_q[b].c - log_q[a].c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic       held_ok;
    logic [3:0] m;

    // Short press of key 2 for 5 cycles; outputs checked #1 after each edge.
    vt[0]  = '{4'b1111, 1'b0, 2'd0, 2'd0, 4'b0000};
    vt[1]  = '{4'b1011, 1'b0, 2'd0, 2'd0, 4'b0000};
    vt[2]  = '{4'b1011, 1'b0, 2'd0, 2'd0, 4'b0100};
    vt[3]  = '{4'b1011, 1'b1, 2'd2, 2'd1, 4'b0100};
    vt[4]  = '{4'b1011, 1'b0, 2'd2, 2'd1, 4'b0100};
    vt[5]  = '{4'b1011, 1'b0, 2'd2, 2'd1, 4'b0100};
    vt[6]  = '{4'b1111, 1'b0, 2'd2, 2'd1, 4'b0100};
    vt[7]  = '{4'b1111, 1'b0, 2'd2, 2'd1, 4'b0000};
    vt[8]  = '{4'b1111, 1'b1, 2'd2, 2'd0, 4'b0000};
    vt[9]  = '{4'b1111, 1'b0, 2'd2, 2'd0, 4'b0000};
    vt[10] = '{4'b1111, 1'b0, 2'd2, 2'd0, 4'b0000};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_key", 32'(evt_key), 0);
    chk("rst_type", 32'(evt_type), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_ovf", 32'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      key_n = vt[i].key_n;
      step(1);
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_key", i), 32'(evt_key), 32'(vt[i].k));
      chk($sformatf("vec%0d_type", i), 32'(evt_type), 32'(vt[i].t));
      chk($sformatf("vec%0d_held", i), 32'(key_held), 32'(vt[i].held));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 0);
    end
    step(3);

    // Simultaneous press of keys 0 and 3.
    log_q.delete();
    key_n = 4'b0110;
    step(6);
    key_n = 4'b1111;
    step(8);
    chk("simul_count", 32'(log_q.size()), 4);
    chk_log("simul_p0", 0, 2'd0, 2'd1);
    chk_log("simul_p3", 1, 2'd3, 2'd1);
    chk("simul_gap", 32'(dcyc(0, 1)), 1);
    chk_log("simul_r0", 2, 2'd0, 2'd0);
    chk_log("simul_r3", 3, 2'd3, 2'd0);
    chk("simul_ovf", 32'(overflow), 0);

    // Long hold of key 1 for 20 cycles.
    log_q.delete();
    held_ok = 1'b1;
    key_n = 4'b1101;
    step(1);
    for (int i = 0; i < 19; i++) begin
      step(1);
      if (key_held[1] !== 1'b1) held_ok = 1'b0;
    end
    key_n = 4'b1111;
    step(1);
    if (key_held[1] !== 1'b1) held_ok = 1'b0;
    step(10);
    chk("hold_held", 32'(held_ok), 1);
    chk("hold_count", 32'(log_q.size()), 5);
    chk_log("hold_press", 0, 2'd1, 2'd1);
    chk_log("hold_long", 1, 2'd1, 2'd2);
    chk_log("hold_rpt1", 2, 2'd1, 2'd3);
    chk_log("hold_rpt2", 3, 2'd1, 2'd3);
    chk_log("hold_rel", 4, 2'd1, 2'd0);
    chk("hold_long_dly", 32'(dcyc(0, 1)), 8);
    chk("hold_rpt1_dly", 32'(dcyc(0, 2)), 12);
    chk("hold_rpt2_dly", 32'(dcyc(0, 3)), 16);
    chk("hold_rel_dly", 32'(dcyc(0, 4)), 20);
    chk("hold_idle_after", 32'(key_held), 0);

    // Backpressure: each key pressed and released in turn with the consumer stalled.
    log_q.delete();
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = 4'b0001 << k;
      key_n = ~m;
      step(3);
      key_n = 4'b1111;
      step(3);
    end
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_head_key", 32'(evt_key), 0);
    chk("bp_head_type", 32'(evt_type), 1);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_none_taken", 32'(log_q.size()), 0);
    evt_ready = 1'b1;
    step(10);
    chk("bp_drain_count", 32'(log_q.size()), 6);
    chk_log("bp_d0", 0, 2'd0, 2'd1);
    chk_log("bp_d1", 1, 2'd0, 2'd0);
    chk_log("bp_d2", 2, 2'd1, 2'd1);
    chk_log("bp_d3", 3, 2'd1, 2'd0);
    chk_log("bp_d4", 4, 2'd2, 2'd1);
    chk_log("bp_d5", 5, 2'd3, 2'd1);
    chk("bp_empty", 32'(evt_valid), 0);
    chk("bp_ovf_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("bp_ovf_clr", 32'(overflow), 0);

    // Release exactly when the hold counter hits its terminal count.
    log_q.delete();
    key_n = 4'b1110;
    step(8);
    key_n = 4'b1111;
    step(8);
    chk("tc_count", 32'(log_q.size()), 2);
    chk_log("tc_press", 0, 2'd0, 2'd1);
    chk_log("tc_rel", 1, 2'd0, 2'd0);
    chk("tc_rel_dly", 32'(dcyc(0, 1)), 8);

    // Reset while key 1 is in the repeat phase with events queued.
    log_q.delete();
    evt_ready = 1'b0;
    key_n = 4'b1101;
    step(16);
    chk("mrst_pre_valid", 32'(evt_valid), 1);
    chk("mrst_pre_held", 32'(key_held), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(evt_valid), 0);
    chk("mrst_held", 32'(key_held), 0);
    chk("mrst_key", 32'(evt_key), 0);
    chk("mrst_type", 32'(evt_type), 0);
    #1 rst_n = 1'b1;
    evt_ready = 1'b1;
    step(1);
    chk("mrst_c1_valid", 32'(evt_valid), 0);
    step(1);
    chk("mrst_c2_valid", 32'(evt_valid), 0);
    chk("mrst_c2_held", 32'(key_held), 32'h2);
    step(1);
    chk("mrst_c3_valid", 32'(evt_valid), 1);
    chk("mrst_c3_key", 32'(evt_key), 1);
    chk("mrst_c3_type", 32'(evt_type), 1);
    key_n = 4'b1111;
    step(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
